// File: rtl/fir_sample_serializer.sv
// rtl/fir_sample_serializer.sv - parallel sample to SPI mode 0 serial DAC shifter
//
// Purpose: output end of the FIR datapath. Accepts one parallel sample per
// valid/ready handshake and shifts it out MSB-first with SPI mode 0 framing
// (sclk idles low, data stable across the rising edge, changes on falling).
//
// Ports:
//   clk      - single clock, all state changes on its rising edge
//   rst      - asynchronous active-low reset
//   s_data   - parallel sample, N bits, passed through unmodified
//   s_valid  - s_data is valid
//   s_ready  - block can accept a sample
//   sclk     - serial clock, idle low, half-period CLK_DIV clk cycles
//   cs_n     - active-low frame select
//   sdo      - serial data, MSB first
//   busy     - inverse of s_ready
module fir_sample_serializer #(
  parameter int N       = 16,
  parameter int CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic         sclk,
  output logic         cs_n,
  output logic         sdo,
  output logic         busy
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(N + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t         state, state_nx;
  logic [N-1:0]   shreg, shreg_nx;
  logic [BW-1:0]  bit_cnt, bit_cnt_nx;
  logic [DW-1:0]  div_cnt, div_cnt_nx;
  logic           s_ready_nx;
  logic           sclk_nx;
  logic           cs_n_nx;

  // sdo is the shift register MSB. The register is cleared at the end of
  // every frame, so sdo reads 0 in GAP and IDLE without a separate flop.
  assign sdo  = shreg[N-1];
  assign busy = ~s_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      s_ready <= 1'b1;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      bit_cnt <= bit_cnt_nx;
      div_cnt <= div_cnt_nx;
      s_ready <= s_ready_nx;
      sclk    <= sclk_nx;
      cs_n    <= cs_n_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    div_cnt_nx = div_cnt;
    s_ready_nx = s_ready;
    sclk_nx    = sclk;
    cs_n_nx    = cs_n;

    case (state)
      IDLE: begin
        // s_ready is registered and only high in IDLE, so a valid arriving
        // on the edge that leaves GAP is not taken until the next edge.
        if (s_valid && s_ready) begin
          state_nx   = SHIFT;
          shreg_nx   = s_data;
          bit_cnt_nx = '0;
          div_cnt_nx = '0;
          s_ready_nx = 1'b0;
          cs_n_nx    = 1'b0;
          sclk_nx    = 1'b0;
        end
      end

      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nx = '0;
          if (!sclk) begin
            sclk_nx = 1'b1;
          end else begin
            sclk_nx = 1'b0;
            if (bit_cnt == BIT_LAST) begin
              // last falling edge closes the frame; no shift follows it
              state_nx   = GAP;
              cs_n_nx    = 1'b1;
              shreg_nx   = '0;
              bit_cnt_nx = '0;
            end else begin
              bit_cnt_nx = bit_cnt + 1'b1;
              shreg_nx   = {shreg[N-2:0], 1'b0};
            end
          end
        end else begin
          div_cnt_nx = div_cnt + 1'b1;
        end
      end

      GAP: begin
        if (div_cnt == DIV_LAST) begin
          state_nx   = IDLE;
          div_cnt_nx = '0;
          s_ready_nx = 1'b1;
        end else begin
          div_cnt_nx = div_cnt + 1'b1;
        end
      end

      default: begin
        state_nx   = IDLE;
        shreg_nx   = '0;
        bit_cnt_nx = '0;
        div_cnt_nx = '0;
        s_ready_nx = 1'b1;
        sclk_nx    = 1'b0;
        cs_n_nx    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_fir_sample_serializer.sv
// tb/tb_fir_sample_serializer.sv - directed bench for fir_sample_serializer
module tb_fir_sample_serializer;

  logic        clk = 1'b0;
  logic        rst;

  logic [15:0] d16;
  logic        v16, r16, sclk16, cs16, sdo16, busy16;
  logic [1:0]  d2;
  logic        v2, r2, sclk2, cs2, sdo2, busy2;
  logic [23:0] d24;
  logic        v24, r24, sclk24, cs24, sdo24, busy24;

  int total = 0;
  int bad   = 0;

  int          f_cs, f_rise, f_gap, f_lat, f_bz;
  logic [31:0] f_bits;

  always #5 clk = ~clk;

  fir_sample_serializer #(.N(16), .CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .s_data(d16), .s_valid(v16), .s_ready(r16),
    .sclk(sclk16), .cs_n(cs16), .sdo(sdo16), .busy(busy16)
  );

  fir_sample_serializer #(.N(2), .CLK_DIV(1)) dut_n2 (
    .clk(clk), .rst(rst), .s_data(d2), .s_valid(v2), .s_ready(r2),
    .sclk(sclk2), .cs_n(cs2), .sdo(sdo2), .busy(busy2)
  );

  fir_sample_serializer #(.N(24), .CLK_DIV(5)) dut_n24 (
    .clk(clk), .rst(rst), .s_data(d24), .s_valid(v24), .s_ready(r24),
    .sclk(sclk24), .cs_n(cs24), .sdo(sdo24), .busy(busy24)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Watches one instance from the sample after its accept edge until s_ready
  // returns. f_lat is measured in clk edges after the accept edge.
  task automatic mon(input int which, input int inj_at, input logic [15:0] inj_d);
    logic cs, sc, so, rd, bz, prev;
    f_cs = 0; f_rise = 0; f_gap = 0; f_lat = 0; f_bz = 0; f_bits = '0;
    prev = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (which == 0 && k == inj_at) begin
        v16 = 1'b1;
        d16 = inj_d;
      end
      case (which)
        0:       begin cs = cs16; sc = sclk16; so = sdo16; rd = r16; bz = busy16; end
        1:       begin cs = cs2;  sc = sclk2;  so = sdo2;  rd = r2;  bz = busy2;  end
        default: begin cs = cs24; sc = sclk24; so = sdo24; rd = r24; bz = busy24; end
      endcase
      if (bz !== ~rd) f_bz++;
      if (cs === 1'b0) f_cs++;
      if (cs === 1'b1 && rd === 1'b0) f_gap++;
      if (sc === 1'b1 && prev === 1'b0) begin
        f_rise++;
        f_bits = {f_bits[30:0], so};
      end
      prev = sc;
      if (rd === 1'b1) begin
        f_lat = k - 1;
        break;
      end
    end
  endtask

  task automatic frame_checks(input string tag, input int e_cs, input int e_rise,
                              input logic [31:0] e_bits, input int e_gap, input int e_lat);
    check({tag, ".cs_low"}, f_cs, e_cs);
    check({tag, ".rises"}, f_rise, e_rise);
    check({tag, ".bits"}, f_bits, e_bits);
    check({tag, ".gap"}, f_gap, e_gap);
    check({tag, ".ready_lat"}, f_lat, e_lat);
    check({tag, ".busy"}, f_bz, 0);
  endtask

  initial begin
    int rises;
    logic prev;

    rst = 1'b0;
    d16 = '0; v16 = 1'b0;
    d2  = '0; v2  = 1'b0;
    d24 = '0; v24 = 1'b0;

    repeat (3) @(negedge clk);
    check("reset.s_ready", r16, 1'b1);
    check("reset.busy", busy16, 1'b0);
    check("reset.cs_n", cs16, 1'b1);
    check("reset.sclk", sclk16, 1'b0);
    check("reset.sdo", sdo16, 1'b0);
    rst = 1'b1;

    // unknown data with no valid must not leak onto sdo
    d16 = 'x;
    repeat (3) @(negedge clk);
    check("idle_x.sdo", sdo16, 1'b0);
    check("idle_x.cs_n", cs16, 1'b1);

    // single frame
    d16 = 16'hA5C3; v16 = 1'b1;
    @(posedge clk); #1 v16 = 1'b0; d16 = 16'h0000;
    mon(0, 0, 16'h0);
    frame_checks("single", 64, 16, 32'h0000A5C3, 2, 66);

    // back-to-back with valid held
    @(negedge clk);
    d16 = 16'h8001; v16 = 1'b1;
    @(posedge clk); #1 d16 = 16'h7FFE;
    mon(0, 0, 16'h0);
    frame_checks("b2b_first", 64, 16, 32'h00008001, 2, 66);
    check("b2b.idle_valid", v16, 1'b1);
    @(posedge clk); #1 v16 = 1'b0;
    mon(0, 0, 16'h0);
    frame_checks("b2b_second", 64, 16, 32'h00007FFE, 2, 66);

    // valid during a frame is ignored until s_ready returns
    @(negedge clk);
    d16 = 16'h0000; v16 = 1'b1;
    @(posedge clk); #1 v16 = 1'b0;
    mon(0, 20, 16'hFFFF);
    frame_checks("ignored_zero", 64, 16, 32'h00000000, 2, 66);
    @(posedge clk); #1 v16 = 1'b0;
    mon(0, 0, 16'h0);
    frame_checks("ignored_ffff", 64, 16, 32'h0000FFFF, 2, 66);

    // reset in the middle of a frame, between clk edges
    @(negedge clk);
    d16 = 16'hFFFF; v16 = 1'b1;
    @(posedge clk); #1 v16 = 1'b0;
    rises = 0; prev = 1'b0;
    for (int k = 0; k < 200 && rises < 5; k++) begin
      @(negedge clk);
      if (sclk16 === 1'b1 && prev === 1'b0) rises++;
      prev = sclk16;
    end
    check("midrst.rises_before", rises, 5);
    check("midrst.cs_before", cs16, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("midrst.cs_n", cs16, 1'b1);
    check("midrst.sclk", sclk16, 1'b0);
    check("midrst.sdo", sdo16, 1'b0);
    check("midrst.s_ready", r16, 1'b1);
    @(negedge clk);
    check("midrst.held_cs_n", cs16, 1'b1);
    rst = 1'b1;
    d16 = 16'h1234; v16 = 1'b1;
    @(posedge clk); #1 v16 = 1'b0;
    mon(0, 0, 16'h0);
    frame_checks("after_rst", 64, 16, 32'h00001234, 2, 66);

    // N=2, CLK_DIV=1
    @(negedge clk);
    d2 = 2'b10; v2 = 1'b1;
    @(posedge clk); #1 v2 = 1'b0;
    mon(1, 0, 16'h0);
    frame_checks("n2_a", 4, 2, 32'h2, 1, 5);
    @(negedge clk);
    d2 = 2'b01; v2 = 1'b1;
    @(posedge clk); #1 v2 = 1'b0;
    mon(1, 0, 16'h0);
    frame_checks("n2_b", 4, 2, 32'h1, 1, 5);

    // N=24, CLK_DIV=5
    @(negedge clk);
    d24 = 24'hC3A55A; v24 = 1'b1;
    @(posedge clk); #1 v24 = 1'b0;
    mon(2, 0, 16'h0);
    frame_checks("n24", 240, 24, 32'h00C3A55A, 5, 245);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_sample_serializer.md
FIR_SAMPLE_SERIALIZER -- requirements
Module: fir_sample_serializer

Purpose: output end of the FIR datapath. Takes one parallel filtered sample per handshake and shifts it MSB-first to a serial DAC (SPI mode 0 framing).

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter N, 16, sample width in bits; legal range N >= 2.
REQ-002 The block SHALL have parameter CLK_DIV, 4, sclk half-period in clk cycles; legal range CLK_DIV >= 1.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-low reset: asserted when 0, takes effect immediately without waiting for a clk edge.
REQ-005 The block SHALL have port s_data, input, N, the parallel sample (two's complement, passed through unmodified).
REQ-006 The block SHALL have port s_valid, input, 1, meaning s_data is valid.
REQ-007 The block SHALL have port s_ready, output, 1, meaning the block can accept a sample.
REQ-008 The block SHALL have port sclk, output, 1, the serial clock; idle level 0.
REQ-009 The block SHALL have port cs_n, output, 1, the active-low frame select.
REQ-010 The block SHALL have port sdo, output, 1, the serial data, MSB first.
REQ-011 The block SHALL have port busy, output, 1, equal to the inverse of s_ready.

Function
REQ-012 The block SHALL implement FSM states IDLE, SHIFT and GAP, with all outputs driven from registers (no combinational path from any input to any output).
REQ-013 In IDLE the block SHALL drive s_ready=1, cs_n=1, sclk=0 and sdo=0.
REQ-014 A transfer SHALL be accepted on the clk edge where s_valid=1 and s_ready=1 (the accept edge).
REQ-015 On the accept edge the block SHALL capture s_data into an internal N-bit shift register and move to SHIFT.
REQ-016 s_data changes after the accept edge SHALL have no effect on the frame in progress.
REQ-017 After the accept edge the block SHALL drive s_ready=0, cs_n=0 and sdo=s_data[N-1], with sclk=0.
REQ-018 In SHIFT, sclk SHALL toggle every CLK_DIV clk cycles, starting low: first rising edge CLK_DIV cycles after the accept edge.
REQ-019 sdo SHALL be stable across each sclk rising edge and SHALL advance to the next lower bit on each sclk falling edge, except the final one.
REQ-020 SHIFT SHALL last exactly 2*N*CLK_DIV clk cycles, producing N sclk rising edges.
REQ-021 A bit counter SHALL track bits sent, at width $clog2(N+1).
REQ-022 At the final sclk falling edge the block SHALL enter GAP with cs_n=1, sclk=0 and sdo=0.
REQ-023 GAP SHALL last CLK_DIV clk cycles and then return to IDLE, with s_ready=1 on the following cycle.
REQ-024 Accept-to-ready latency SHALL be (2*N+1)*CLK_DIV cycles; maximum throughput is one sample per (2*N+1)*CLK_DIV+1 cycles.
REQ-025 s_valid while s_ready=0 SHALL be ignored. The upstream source holds s_valid and s_data until accepted; the block drops no sample that was handshaken.
REQ-026 s_valid asserted on the same edge that GAP returns to IDLE SHALL NOT be accepted on that edge; it is accepted on the next edge if still asserted.
REQ-027 X or unknown values on s_data while s_valid=0 SHALL NOT propagate to sdo.

Reset
REQ-028 When rst=0 the block SHALL asynchronously force: state=IDLE, shift register=0, bit counter=0, divider counter=0, s_ready=1, busy=0, cs_n=1, sclk=0, sdo=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately: cs_n rises without waiting for a clk edge, and no partial-frame completion follows.
REQ-030 After rst deasserts, the first accept SHALL be possible on the first clk edge.

Verification (N=16 and CLK_DIV=2 unless stated)
REQ-031 The bench SHALL cover single frame: s_data=16'hA5C3 with s_valid pulsed. Required: cs_n low for 64 cycles; bits sampled on sclk rising edges are 1010_0101_1100_0011; exactly 16 rising edges; s_ready=1 again 66 cycles after the accept edge.
REQ-032 The bench SHALL cover back-to-back: s_valid held high with 16'h8001 then 16'h7FFE. Required: two frames separated by exactly 2 cycles of cs_n=1 plus 1 IDLE cycle; second frame bits 0111_1111_1111_1110.
REQ-033 The bench SHALL cover ignored input: s_valid=1 with s_data=16'hFFFF mid-frame of 16'h0000. Required: the frame outputs all zeros, and the 16'hFFFF sample is accepted only after s_ready returns.
REQ-034 The bench SHALL cover mid-frame reset: rst=0 after 5 rising sclk edges, asserted between clk edges. Required: cs_n=1, sclk=0, sdo=0 and s_ready=1 immediately; after release, a new frame of 16'h1234 is correct.
REQ-035 The bench SHALL cover parameter corners: N=2 with CLK_DIV=1, and N=24 with CLK_DIV=5. Required: frame length 2*N*CLK_DIV, correct MSB-first data, and gap of CLK_DIV cycles in both configurations.
